regfile_multiport: RTL and testbench
====================================

REGFILE_MULTIPORT -- requirements
Module: regfile_multiport

Interface
REQ-001 The module SHALL have parameter DWIDTH, default 32: data word width in bits, a multiple of 8.
REQ-002 The module SHALL have parameter AWIDTH, default 5: address width, giving depth 2**AWIDTH.
REQ-003 The module SHALL have parameter NRD, default 2: number of independent read ports, 1..4.
REQ-004 The module SHALL have port CLK, input, 1 bit: single clock, rising edge.
REQ-005 The module SHALL have port RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The module SHALL have port CLR, input, 1 bit: start a full-array clear sequence.
REQ-007 The module SHALL have port BUSY, output, 1 bit: clear sequence in progress.
REQ-008 The module SHALL have port WE, input, 1 bit: write enable.
REQ-009 The module SHALL have port WA, input, AWIDTH bits: write address.
REQ-010 The module SHALL have port WBE, input, DWIDTH/8 bits: per-byte write enables.
REQ-011 The module SHALL have port DataIn, input, DWIDTH bits: write data.
REQ-012 The module SHALL have port RE, input, NRD bits: per-port read enables.
REQ-013 The module SHALL have port RA, input, NRD*AWIDTH bits: read addresses, port k at [k*AWIDTH +: AWIDTH].
REQ-014 The module SHALL have port DOUT, output, NRD*DWIDTH bits: registered read data, port k at [k*DWIDTH +: DWIDTH].
REQ-015 The module SHALL have port DVALID, output, NRD bits: DOUT slice k updated this cycle.

Function
REQ-016 Write SHALL commit on the CLK edge when WE=1 and BUSY=0; only bytes with WBE[i]=1 update; WE with WBE all-zero SHALL be a no-op.
REQ-017 Read port k SHALL have 1-cycle latency: with RE[k]=1 and BUSY=0 at edge n, DOUT slice k holds array[RA_k] and DVALID[k]=1 after edge n.
REQ-018 With RE[k]=0, DOUT slice k SHALL hold its previous value (never Z) and DVALID[k] SHALL be 0.
REQ-019 Multiple ports reading the same address in one cycle SHALL all return identical data.
REQ-020 The clear FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on CLR=1; CLEAR->IDLE after the entry at address 2**AWIDTH-1 is zeroed.
REQ-021 In CLEAR, one entry per cycle SHALL be zeroed, ascending from 0 using an AWIDTH-bit counter, so the sequence takes exactly 2**AWIDTH cycles.
REQ-022 BUSY SHALL equal (state==CLEAR).
REQ-023 While BUSY=1, WE and RE SHALL be ignored, DVALID SHALL be all zeros, and DOUT SHALL hold.
REQ-024 CLR asserted while BUSY=1 SHALL be ignored; it SHALL NOT restart the counter.

Reset
REQ-025 RST_N=0 SHALL asynchronously set the FSM to CLEAR, the counter to 0, DOUT to all zeros and DVALID to all zeros.
REQ-026 After RST_N deasserts, the array SHALL be fully zeroed after 2**AWIDTH cycles, with BUSY=1 throughout.
REQ-027 Reset asserted mid-clear SHALL restart the clear from address 0.
REQ-028 Array storage SHALL NOT itself be async-reset; zeroing is done only by the FSM.

Configuration
REQ-029 With macro REGFILE_BYPASS_EN defined, a read of address A at the same edge as a write to A (BUSY=0) SHALL return the merged new data, i.e. written bytes new and unwritten bytes old (write-first).
REQ-030 Without REGFILE_BYPASS_EN, the same collision SHALL return the pre-write contents (read-first).

Structure
REQ-031 Package regfile_pkg SHALL hold the FSM state typedef (IDLE, CLEAR) and the default parameter constants.
REQ-032 The clear sequencer (FSM plus counter, outputs BUSY, clear address and clear strobe) SHALL be the sub-module regfile_clr_fsm; the array and read ports SHALL stay in the top module.

Verification
REQ-033 Reset with RST_N low then high -> BUSY=1 for exactly 32 cycles (AWIDTH=5), then 0; reading all addresses returns 0.
REQ-034 Write 0xDEADBEEF to 3 with WBE=4'hF, then WBE=4'b0010 with DataIn 0x0000AA00 -> read of 3 gives 0xDEADAAEF.
REQ-035 Port0 RA=3 and port1 RA=3 in the same cycle -> both DOUT slices equal 0xDEADAAEF and DVALID=2'b11 one cycle later.
REQ-036 Write 0x12345678 to 7 while port0 reads 7 (old value 0) -> port0 returns 0x12345678 with REGFILE_BYPASS_EN defined, 0x00000000 without it.
REQ-037 CLR pulse, then WE=1 to 5 at clear cycle 10 -> write dropped, address 5 reads 0 after BUSY falls; a second CLR at cycle 12 does not extend BUSY beyond 32 cycles.
REQ-038 RST_N pulsed low at clear cycle 20 -> DOUT and DVALID go 0 immediately, and BUSY stays high for 32 further cycles after release.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the multi-port register file.
// Clear-sequencer state encoding lives here so the top and the FSM agree on it.
package regfile_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int AWIDTH_DEF = 5;
  localparam int NRD_DEF    = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: walks every array address once, zeroing one entry per cycle.
// Reset lands in CLEAR so the array is always wiped after power-up.
module regfile_clr_fsm
  import regfile_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  output logic              busy,
  output logic [AWIDTH-1:0] clr_addr,
  output logic              clr_stb
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = '1;

  clr_state_t        state;
  logic [AWIDTH-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            cnt   <= '0;
          end
        end
        CLEAR: begin
          // clr is deliberately not looked at here: a running sweep is never restarted.
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ADDR) state <= IDLE;
        end
      endcase
    end
  end

  assign busy     = (state == CLEAR);
  assign clr_stb  = (state == CLEAR);
  assign clr_addr = cnt;

endmodule

// File: rtl/regfile_multiport.sv
// Multi-port register file: one byte-masked write port, NRD registered read ports.
// Define REGFILE_BYPASS_EN for write-first collisions; default build is read-first.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int NRD    = NRD_DEF
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     CLR,
  output logic                     BUSY,
  input  logic                     WE,
  input  logic [AWIDTH-1:0]        WA,
  input  logic [DWIDTH/8-1:0]      WBE,
  input  logic [DWIDTH-1:0]        DataIn,
  input  logic [NRD-1:0]           RE,
  input  logic [NRD*AWIDTH-1:0]    RA,
  output logic [NRD*DWIDTH-1:0]    DOUT,
  output logic [NRD-1:0]           DVALID
);

  localparam int DEPTH  = 2**AWIDTH;
  localparam int NBYTES = DWIDTH/8;

  logic [DWIDTH-1:0]            mem [DEPTH];
  logic [AWIDTH-1:0]            clr_addr;
  logic                         clr_stb;
  logic                         wr_en;
  logic [NRD-1:0][DWIDTH-1:0]   rd_word;
  logic [NRD-1:0][DWIDTH-1:0]   dout_q;

  regfile_clr_fsm #(.AWIDTH(AWIDTH)) u_clr_fsm (
    .clk      (CLK),
    .rst_n    (RST_N),
    .clr      (CLR),
    .busy     (BUSY),
    .clr_addr (clr_addr),
    .clr_stb  (clr_stb)
  );

  assign wr_en = WE && !BUSY;

  // NOTE: the array has no reset so it maps onto RAM; the clear sequencer zeroes it instead.
  always_ff @(posedge CLK) begin
    if (clr_stb) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (WBE[i]) mem[WA][i*8 +: 8] <= DataIn[i*8 +: 8];
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic [DWIDTH-1:0] wr_merged;

  always_comb begin
    wr_merged = mem[WA];
    for (int i = 0; i < NBYTES; i++) begin
      if (WBE[i]) wr_merged[i*8 +: 8] = DataIn[i*8 +: 8];
    end
  end
`endif

  // NOTE: every always_comb output gets a full default first so no latch can be inferred.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_word[k] = mem[RA[k*AWIDTH +: AWIDTH]];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && (WA == RA[k*AWIDTH +: AWIDTH])) rd_word[k] = wr_merged;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      dout_q <= '0;
      DVALID <= '0;
    end else begin
      for (int k = 0; k < NRD; k++) begin
        DVALID[k] <= RE[k] && !BUSY;
        if (RE[k] && !BUSY) dout_q[k] <= rd_word[k];
      end
    end
  end

  assign DOUT = dout_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport (default parameters, NRD=2).
// Build with REGFILE_BYPASS_EN to expect write-first collision results.
module tb_regfile_multiport;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 32;

  logic            CLK    = 1'b0;
  logic            RST_N  = 1'b0;
  logic            CLR    = 1'b0;
  logic            BUSY;
  logic            WE     = 1'b0;
  logic [AW-1:0]   WA     = '0;
  logic [DW/8-1:0] WBE    = '0;
  logic [DW-1:0]   DataIn = '0;
  logic [NRD-1:0]  RE     = '0;
  logic [NRD*AW-1:0] RA   = '0;
  logic [NRD*DW-1:0] DOUT;
  logic [NRD-1:0]  DVALID;

  always #5 CLK = ~CLK;

  regfile_multiport #(.DWIDTH(DW), .AWIDTH(AW), .NRD(NRD)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .CLR    (CLR),
    .BUSY   (BUSY),
    .WE     (WE),
    .WA     (WA),
    .WBE    (WBE),
    .DataIn (DataIn),
    .RE     (RE),
    .RA     (RA),
    .DOUT   (DOUT),
    .DVALID (DVALID)
  );

  typedef struct {
    int            port;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t       sb[$];
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_dout [NRD];
  int            compared   = 0;
  int            mismatched = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [DW/8-1:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < DW/8; i++) if (be[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  // One clock; afterwards every DVALID must match a scoreboard entry and idle ports must hold.
  task automatic cycle_mon();
    rd_exp_t e;
    @(posedge CLK);
    #1;
    for (int k = 0; k < NRD; k++) begin
      compared++;
      if (DVALID[k]) begin
        if (sb.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_dvalid port %0d: DVALID=1, required 0", k);
        end else begin
          e = sb.pop_front();
          if (e.port != k || DOUT[k*DW +: DW] !== e.data) begin
            mismatched++;
            $display("FAIL read_data port %0d: got %h, required %h (queued for port %0d)",
                     k, DOUT[k*DW +: DW], e.data, e.port);
          end
          last_dout[k] = e.data;
        end
      end else if (DOUT[k*DW +: DW] !== last_dout[k]) begin
        mismatched++;
        $display("FAIL dout_hold port %0d: got %h, required %h", k, DOUT[k*DW +: DW], last_dout[k]);
      end
    end
  endtask

  // One idle-time transaction: optional write plus reads on the ports flagged in re.
  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW/8-1:0] wbe,
                       input logic [DW-1:0] din, input logic [NRD-1:0] re,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    logic [AW-1:0] ra [NRD];
    logic [DW-1:0] exp_w;
    rd_exp_t       e;
    compared++;
    if (BUSY !== 1'b0) begin
      mismatched++;
      $display("FAIL busy_before_access: BUSY=%b, required 0", BUSY);
    end
    ra[0] = ra0;
    ra[1] = ra1;
    WE = we; WA = wa; WBE = wbe; DataIn = din; RE = re; RA = {ra1, ra0};
    for (int k = 0; k < NRD; k++) begin
      if (re[k]) begin
        exp_w = model[ra[k]];
        if (BYPASS && we && wa == ra[k]) exp_w = merge(model[ra[k]], din, wbe);
        e.port = k;
        e.data = exp_w;
        sb.push_back(e);
      end
    end
    cycle_mon();
    if (we) model[wa] = merge(model[wa], din, wbe);
    WE = 1'b0;
    RE = '0;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL missing_dvalid: %0d reads outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Counts post-edge samples with BUSY high; optional mid-clear write/read/CLR stimulus.
  task automatic count_busy(output int n, input bit poke);
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin
      n++;
      if (poke && n == 10) begin
        WE = 1'b1; WA = 5'd5; WBE = 4'hF; DataIn = 32'h5555_5555;
        RE = 2'b11; RA = {5'd5, 5'd5};
      end
      if (poke && n == 12) CLR = 1'b1;
      cycle_mon();
      WE = 1'b0; RE = '0; CLR = 1'b0;
    end
  endtask

  task automatic test_reset();
    int n;
    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    compared += 3;
    if (BUSY !== 1'b1) begin mismatched++; $display("FAIL reset_busy: got %b, required 1", BUSY); end
    if (DOUT !== '0) begin mismatched++; $display("FAIL reset_dout: got %h, required 0", DOUT); end
    if (DVALID !== '0) begin mismatched++; $display("FAIL reset_dvalid: got %b, required 0", DVALID); end
    for (int k = 0; k < NRD; k++) last_dout[k] = '0;
    model_zero();
    RST_N = 1'b1;
    count_busy(n, 1'b0);
    compared++;
    if (n != 32) begin mismatched++; $display("FAIL reset_busy_len: got %0d cycles, required 32", n); end
    for (int i = 0; i < DEPTH; i++) drive(1'b0, '0, '0, '0, 2'b11, AW'(i), AW'(DEPTH-1-i));
  endtask

  task automatic test_byte_enable();
    drive(1'b1, 5'd3, 4'hF, 32'hDEAD_BEEF, 2'b00, '0, '0);
    drive(1'b1, 5'd3, 4'b0010, 32'h0000_AA00, 2'b00, '0, '0);
    drive(1'b1, 5'd3, 4'h0, 32'h1111_1111, 2'b00, '0, '0);
    drive(1'b0, '0, '0, '0, 2'b01, 5'd3, '0);
    compared++;
    if (DOUT[31:0] !== 32'hDEAD_AAEF) begin
      mismatched++;
      $display("FAIL byte_enable: got %h, required deadaaef", DOUT[31:0]);
    end
  endtask

  task automatic test_same_addr();
    drive(1'b0, '0, '0, '0, 2'b11, 5'd3, 5'd3);
    compared += 2;
    if (DVALID !== 2'b11) begin mismatched++; $display("FAIL same_addr_dvalid: got %b, required 11", DVALID); end
    if (DOUT !== {32'hDEAD_AAEF, 32'hDEAD_AAEF}) begin
      mismatched++;
      $display("FAIL same_addr_data: got %h, required deadaaefdeadaaef", DOUT);
    end
    drive(1'b0, '0, '0, '0, 2'b00, '0, '0);
    compared++;
    if (DVALID !== 2'b00) begin mismatched++; $display("FAIL idle_dvalid: got %b, required 00", DVALID); end
  endtask

  task automatic test_collision();
    logic [DW-1:0] want;
    want = BYPASS ? 32'h1234_5678 : 32'h0000_0000;
    drive(1'b1, 5'd7, 4'hF, 32'h1234_5678, 2'b01, 5'd7, '0);
    compared++;
    if (DOUT[31:0] !== want) begin
      mismatched++;
      $display("FAIL collision: got %h, required %h", DOUT[31:0], want);
    end
    drive(1'b0, '0, '0, '0, 2'b10, '0, 5'd7);
  endtask

  task automatic test_clear_busy();
    int n;
    drive(1'b1, 5'd5, 4'hF, 32'hAAAA_AAAA, 2'b00, '0, '0);
    drive(1'b0, '0, '0, '0, 2'b11, 5'd5, 5'd3);
    CLR = 1'b1;
    cycle_mon();
    CLR = 1'b0;
    count_busy(n, 1'b1);
    compared++;
    if (n != 32) begin mismatched++; $display("FAIL clear_busy_len: got %0d cycles, required 32", n); end
    model_zero();
    drive(1'b0, '0, '0, '0, 2'b11, 5'd5, 5'd3);
    compared++;
    if (DOUT !== '0) begin mismatched++; $display("FAIL clear_dropped_write: got %h, required 0", DOUT); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    drive(1'b1, 5'd9, 4'hF, 32'hCAFE_F00D, 2'b00, '0, '0);
    drive(1'b0, '0, '0, '0, 2'b11, 5'd9, 5'd9);
    CLR = 1'b1;
    cycle_mon();
    CLR = 1'b0;
    for (int i = 1; i < 20; i++) cycle_mon();
    RST_N = 1'b0;
    #2;
    compared += 3;
    if (DOUT !== '0) begin mismatched++; $display("FAIL midreset_dout: got %h, required 0", DOUT); end
    if (DVALID !== '0) begin mismatched++; $display("FAIL midreset_dvalid: got %b, required 0", DVALID); end
    if (BUSY !== 1'b1) begin mismatched++; $display("FAIL midreset_busy: got %b, required 1", BUSY); end
    for (int k = 0; k < NRD; k++) last_dout[k] = '0;
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    count_busy(n, 1'b0);
    compared++;
    if (n != 32) begin mismatched++; $display("FAIL midreset_busy_len: got %0d cycles, required 32", n); end
    model_zero();
    drive(1'b0, '0, '0, '0, 2'b01, 5'd9, '0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom), AW'($urandom_range(0, 7)), 4'($urandom), $urandom,
            2'($urandom), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    test_reset();
    test_byte_enable();
    test_same_addr();
    test_collision();
    test_clear_busy();
    test_reset_mid_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1, "watchdog");
  end

endmodule
